compressed_fetch_aligner: RTL and testbench
===========================================

# compressed_fetch_aligner

Parametrised fetch-side aligner for RVC. It replaces the fixed one-cycle compressed stall with a halfword buffer. The block sits between the instruction-memory fetch stage and decode. It accepts fetch words of FETCH_HW halfwords, packs them into a halfword FIFO, and issues exactly one 16- or 32-bit instruction per cycle with its PC. Instructions may straddle fetch words and may start misaligned after a redirect. The block stalls fetch only when the buffer lacks room, and counts those stall cycles.

## Interface
- FETCH_HW, 2, halfwords per fetch word (2 = 32-bit fetch, 4 = 64-bit fetch); power of two.
- BUF_HW, 6, buffer depth in halfwords; must be >= FETCH_HW+1.
- XLEN, 32, PC width.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- fetch_valid  in  1  fetch word present.
- fetch_data  in  16*FETCH_HW  fetch word; halfword 0 in bits [15:0] is at the lowest address.
- fetch_pc  in  XLEN  address of fetch_data, aligned to 2*FETCH_HW bytes.
- fetch_ready  out  1  buffer can take a whole fetch word this cycle.
- flush  in  1  redirect; has priority over all other inputs.
- flush_pc  in  XLEN  redirect target; bit 0 is ignored.
- instr_valid  out  1  complete instruction at buffer head.
- instr_ready  in  1  decode consumes the instruction.
- instr  out  32  instruction; compressed forms are zero-extended {16'h0, hw}.
- instr_pc  out  XLEN  PC of instr.
- instr_compressed  out  1  head halfword bits [1:0] != 2'b11.
- stall_fetch  out  1  fetch_valid & ~fetch_ready.
- stall_count  out  16  saturating count of stall_fetch cycles; cleared only by reset.

## Operation
- State:
  - halfword FIFO (BUF_HW entries), rd/wr pointers with wrap-around, count 0..BUF_HW;
  - head_pc register;
  - drop register (0..FETCH_HW-1), the halfwords to discard from the next accepted word;
  - pc_load flag.
- Reset value of every output:
  - buffer empty, count 0, head_pc 0, drop 0, pc_load 1, stall_count 0;
  - instr_valid 0, instr/instr_pc 0, fetch_ready 1.
- fetch_ready = (BUF_HW - count) >= FETCH_HW. It uses only registered count, with no combinational path from instr_ready.
- Push when fetch_valid & fetch_ready & ~flush:
  - write halfwords drop..FETCH_HW-1 of fetch_data, in address order;
  - clear drop;
  - if pc_load, set head_pc = fetch_pc + 2*drop and clear pc_load.
- Head decode:
  - 16-bit if head[1:0] != 2'b11 and count >= 1;
  - 32-bit if head[1:0] == 2'b11 and count >= 2, with instr = {hw[rd+1], hw[rd]};
  - instr_valid otherwise 0.
- Pop when instr_valid & instr_ready & ~flush:
  - rd advances by 1 (compressed) or 2;
  - head_pc advances by 2 or 4;
  - count decrements accordingly.
- Push and pop in the same cycle are legal. Count updates by (pushed - popped).
- flush: at the next edge
  - clear FIFO;
  - drop = flush_pc[log2(FETCH_HW):1];
  - set pc_load;
  - head_pc is don't-care until reload.
  - In the flush cycle, instr_valid is forced 0 and push/pop are suppressed.
- A mid-flight 32-bit instruction whose upper half never arrives stays at the head with instr_valid 0. It is never issued partially.
- stall_count increments each cycle stall_fetch = 1 and holds at 16'hFFFF.

## Timing
- Word accepted at edge N → its first instruction is visible combinationally from cycle N+1 (1-cycle latency).
- Steady state is one instruction per cycle. A 32-bit fetch with all-32-bit code never stalls. A 32-bit fetch with all-RVC code drains 2 per word and back-pressures.
- A straddling 32-bit instruction issues the cycle after its second word is accepted.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). The first edge after deassertion behaves as after flush to PC 0.

## Test plan
- Reset: hold reset_n=0 with fetch_valid=1 → instr_valid=0, fetch_ready=1, stall_count=0. After release, push word 0x00000013 @0x100 → next cycle instr=0x00000013, instr_pc=0x100, instr_compressed=0.
- Two RVC per word: 0x4505_4501 @0x100 → instr 0x00004501 @0x100, then 0x00004505 @0x102, on consecutive cycles.
- Straddle: 0x0513_4501 @0x100, then 0x4505_0000 @0x104 → 0x4501 @0x100, 0x00000513 @0x102, 0x4505 @0x106.
- Misaligned redirect:
  - flush with flush_pc=0x202, then 0x4505_4501 @0x200 → only 0x4505 @0x202 is issued.
  - flush asserted with instr_valid=1 → no pop, buffer empty next cycle.
- Back-pressure (BUF_HW=6, FETCH_HW=2): instr_ready=0, push 3 words → count 6 and fetch_ready=0. A 4th word gives stall_fetch=1 and stall_count +1 per cycle. instr_ready=1 for 1 cycle on a 32-bit head → fetch_ready=1 next cycle.
- Simultaneous push+pop at count=4 (2-halfword push, 1 RVC pop) → count 5 with pointers wrapped correctly. Saturation: force 70000 stall cycles → stall_count=16'hFFFF.

Source files
------------

// File: rtl/compressed_fetch_aligner.sv
// Fetch-side RVC aligner: packs fetch words into a halfword FIFO and issues one
// 16- or 32-bit instruction per cycle with its PC, stalling fetch only when full.
module compressed_fetch_aligner #(
    parameter int unsigned FETCH_HW = 2,
    parameter int unsigned BUF_HW   = 6,
    parameter int unsigned XLEN     = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fetch_valid,
    input  logic [16*FETCH_HW-1:0] fetch_data,
    input  logic [XLEN-1:0]        fetch_pc,
    output logic                   fetch_ready,
    input  logic                   flush,
    input  logic [XLEN-1:0]        flush_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [31:0]            instr,
    output logic [XLEN-1:0]        instr_pc,
    output logic                   instr_compressed,
    output logic                   stall_fetch,
    output logic [15:0]            stall_count
);

    localparam int unsigned PTR_W  = (BUF_HW > 1) ? $clog2(BUF_HW) : 1;
    localparam int unsigned CNT_W  = $clog2(BUF_HW + 1);
    localparam int unsigned DROP_W = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;
    localparam int unsigned SUM_W  = PTR_W + 2;

    logic [15:0]       mem_q [BUF_HW];
    logic [15:0]       mem_d [BUF_HW];
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   head_pc_q, head_pc_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              pc_load_q, pc_load_d;
    logic [15:0]       stall_count_q, stall_count_d;

    logic [15:0]       head_hw, next_hw;
    logic              head_is_c, push, pop;
    logic [CNT_W-1:0]  n_push, n_pop;
    logic              unused_flush_pc_bits;

    assign unused_flush_pc_bits = ^{flush_pc[XLEN-1:DROP_W+1], flush_pc[0]};

    // Circular pointer advance; n never exceeds BUF_HW so one subtraction wraps.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [PTR_W:0]   n);
        logic [SUM_W-1:0] s;
        s = SUM_W'(p) + SUM_W'(n);
        if (s >= SUM_W'(BUF_HW)) s = s - SUM_W'(BUF_HW);
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        mem_d            = mem_q;
        rd_d             = rd_q;
        wr_d             = wr_q;
        count_d          = count_q;
        head_pc_d        = head_pc_q;
        drop_d           = drop_q;
        pc_load_d        = pc_load_q;
        stall_count_d    = stall_count_q;

        head_hw          = mem_q[rd_q];
        next_hw          = mem_q[ptr_add(rd_q, (PTR_W+1)'(1))];
        head_is_c        = (head_hw[1:0] != 2'b11);
        instr_compressed = head_is_c;
        instr_valid      = ~flush & (head_is_c ? (count_q >= CNT_W'(1))
                                               : (count_q >= CNT_W'(2)));
        instr            = 32'h0;
        if (instr_valid) instr = head_is_c ? {16'h0, head_hw} : {next_hw, head_hw};
        instr_pc         = head_pc_q;

        fetch_ready      = (count_q <= CNT_W'(BUF_HW - FETCH_HW));
        stall_fetch      = fetch_valid & ~fetch_ready;
        push             = fetch_valid & fetch_ready & ~flush;
        pop              = instr_valid & instr_ready;
        n_push           = CNT_W'(FETCH_HW) - CNT_W'(drop_q);
        n_pop            = head_is_c ? CNT_W'(1) : CNT_W'(2);

        // Leading halfwords below a misaligned redirect target are discarded.
        if (push) begin
            for (int unsigned i = 0; i < FETCH_HW; i++) begin
                if (i >= 32'(drop_q))
                    mem_d[ptr_add(wr_q, (PTR_W+1)'(i - 32'(drop_q)))] = fetch_data[16*i +: 16];
            end
            wr_d   = ptr_add(wr_q, (PTR_W+1)'(n_push));
            drop_d = '0;
            if (pc_load_q) begin
                head_pc_d = fetch_pc + XLEN'({drop_q, 1'b0});
                pc_load_d = 1'b0;
            end
        end
        if (pop) begin
            rd_d      = ptr_add(rd_q, (PTR_W+1)'(n_pop));
            head_pc_d = head_pc_q + XLEN'({n_pop, 1'b0});
        end
        count_d = count_q + (push ? n_push : CNT_W'(0)) - (pop ? n_pop : CNT_W'(0));

        if (flush) begin
            rd_d      = '0;
            wr_d      = '0;
            count_d   = '0;
            pc_load_d = 1'b1;
            drop_d    = (FETCH_HW > 1) ? flush_pc[DROP_W:1] : '0;
        end

        if (stall_fetch && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
        stall_count = stall_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q         <= '{default: '0};
            rd_q          <= '0;
            wr_q          <= '0;
            count_q       <= '0;
            head_pc_q     <= '0;
            drop_q        <= '0;
            pc_load_q     <= 1'b1;
            stall_count_q <= '0;
        end else begin
            mem_q         <= mem_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            count_q       <= count_d;
            head_pc_q     <= head_pc_d;
            drop_q        <= drop_d;
            pc_load_q     <= pc_load_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_compressed_fetch_aligner.sv
// Directed bench for compressed_fetch_aligner (FETCH_HW=2, BUF_HW=6, XLEN=32).
module tb_compressed_fetch_aligner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_compressed;
    logic        stall_fetch;
    logic [15:0] stall_count;

    int checks   = 0;
    int failures = 0;

    compressed_fetch_aligner #(.FETCH_HW(2), .BUF_HW(6), .XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .flush(flush), .flush_pc(flush_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_compressed(instr_compressed),
        .stall_fetch(stall_fetch), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic v, input logic [31:0] d, input logic [31:0] pc);
        fetch_valid = v;
        fetch_data  = d;
        fetch_pc    = pc;
    endtask

    // One cycle: move to the falling edge, drive, then let combinational outputs settle.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] i, input logic [31:0] pc,
                                input logic c);
        chk({tag, "_valid"}, 32'(instr_valid), 32'h1);
        chk({tag, "_instr"}, instr, i);
        chk({tag, "_pc"}, instr_pc, pc);
        chk({tag, "_compressed"}, 32'(instr_compressed), 32'(c));
    endtask

    logic [31:0] exp_i  [7];
    logic [31:0] exp_pc [7];

    initial begin
        reset_n = 1'b0; flush = 1'b0; flush_pc = '0; instr_ready = 1'b0;
        fetch(1'b1, 32'h0000_0013, 32'h100);

        // Reset held with fetch_valid high
        step(); #1;
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_ready", 32'(fetch_ready), 1);
        chk("rst_stall_count", 32'(stall_count), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);

        // First word after release
        step(); reset_n = 1'b1; instr_ready = 1'b1; #1;
        chk("first_pre_valid", 32'(instr_valid), 0);
        step(); fetch(1'b0, 0, 0); #1;
        expect_instr("first", 32'h0000_0013, 32'h100, 1'b0);
        step(); #1;
        chk("first_drained", 32'(instr_valid), 0);

        // Two RVC per word
        flush = 1'b1; flush_pc = 32'h100; #1;
        chk("flush1_valid", 32'(instr_valid), 0);
        step(); flush = 1'b0; fetch(1'b1, 32'h4505_4501, 32'h100);
        step(); fetch(1'b0, 0, 0); #1;
        expect_instr("rvc0", 32'h0000_4501, 32'h100, 1'b1);
        step(); #1;
        expect_instr("rvc1", 32'h0000_4505, 32'h102, 1'b1);
        step(); #1;
        chk("rvc_drained", 32'(instr_valid), 0);

        // Straddling 32-bit instruction
        flush = 1'b1; flush_pc = 32'h100;
        step(); flush = 1'b0; fetch(1'b1, 32'h0513_4501, 32'h100);
        step(); fetch(1'b0, 0, 0); #1;
        expect_instr("str0", 32'h0000_4501, 32'h100, 1'b1);
        step(); fetch(1'b1, 32'h4505_0000, 32'h104); #1;
        chk("str_partial_valid", 32'(instr_valid), 0);
        step(); fetch(1'b0, 0, 0); #1;
        expect_instr("str1", 32'h0000_0513, 32'h102, 1'b0);
        step(); #1;
        expect_instr("str2", 32'h0000_4505, 32'h106, 1'b1);
        step(); #1;
        chk("str_drained", 32'(instr_valid), 0);

        // Misaligned redirect drops the lower halfword
        flush = 1'b1; flush_pc = 32'h202;
        step(); flush = 1'b0; fetch(1'b1, 32'h4505_4501, 32'h200);
        step(); fetch(1'b0, 0, 0); #1;
        expect_instr("mis", 32'h0000_4505, 32'h202, 1'b1);
        step(); #1;
        chk("mis_drained", 32'(instr_valid), 0);

        // Flush while an instruction is valid
        instr_ready = 1'b0; fetch(1'b1, 32'h0000_0013, 32'h204);
        step(); fetch(1'b0, 0, 0); flush = 1'b1; flush_pc = 32'h400; instr_ready = 1'b1; #1;
        chk("flushv_forced", 32'(instr_valid), 0);
        chk("flushv_instr", instr, 0);
        step(); flush = 1'b0; instr_ready = 1'b0; #1;
        chk("flushv_empty", 32'(instr_valid), 0);
        chk("flushv_ready", 32'(fetch_ready), 1);

        // Back-pressure
        fetch(1'b1, 32'h0000_0013, 32'h400); #1;
        chk("bp_ready0", 32'(fetch_ready), 1);
        step(); fetch(1'b1, 32'h0000_0013, 32'h404); #1;
        chk("bp_ready1", 32'(fetch_ready), 1);
        step(); fetch(1'b1, 32'h0000_0013, 32'h408); #1;
        chk("bp_ready2", 32'(fetch_ready), 1);
        step(); fetch(1'b1, 32'h0000_0013, 32'h40c); #1;
        chk("bp_full_ready", 32'(fetch_ready), 0);
        chk("bp_stall", 32'(stall_fetch), 1);
        chk("bp_stall_count0", 32'(stall_count), 0);
        expect_instr("bp_head", 32'h0000_0013, 32'h400, 1'b0);
        step(); #1;
        chk("bp_stall_count1", 32'(stall_count), 1);
        step(); instr_ready = 1'b1; #1;
        chk("bp_stall_count2", 32'(stall_count), 2);
        chk("bp_pop_valid", 32'(instr_valid), 1);
        step(); instr_ready = 1'b0; #1;
        chk("bp_reopen_ready", 32'(fetch_ready), 1);
        chk("bp_reopen_stall", 32'(stall_fetch), 0);
        chk("bp_stall_count3", 32'(stall_count), 3);
        chk("bp_head_pc", instr_pc, 32'h404);
        step(); fetch(1'b0, 0, 0); #1;
        chk("bp_refull_ready", 32'(fetch_ready), 0);

        // Simultaneous push + pop with pointer wrap
        flush = 1'b1; flush_pc = 32'h500;
        step(); flush = 1'b0; fetch(1'b1, 32'h4505_4501, 32'h500);
        step(); fetch(1'b1, 32'h450d_4509, 32'h504);
        step(); fetch(1'b1, 32'h4515_4511, 32'h508); instr_ready = 1'b1; #1;
        expect_instr("pp0", 32'h0000_4501, 32'h500, 1'b1);
        step(); fetch(1'b0, 0, 0); #1;
        chk("pp_count5_ready", 32'(fetch_ready), 0);
        expect_instr("pp1", 32'h0000_4505, 32'h502, 1'b1);
        step(); fetch(1'b1, 32'h451d_4519, 32'h50c); #1;
        chk("pp_count4_ready", 32'(fetch_ready), 1);
        expect_instr("pp2", 32'h0000_4509, 32'h504, 1'b1);
        exp_i  = '{32'h450d, 32'h4511, 32'h4515, 32'h4519, 32'h451d, 32'h0, 32'h0};
        exp_pc = '{32'h506, 32'h508, 32'h50a, 32'h50c, 32'h50e, 32'h0, 32'h0};
        step(); fetch(1'b0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            expect_instr($sformatf("pp_drain%0d", k), exp_i[k], exp_pc[k], 1'b1);
            step();
        end
        #1;
        chk("pp_drained", 32'(instr_valid), 0);

        // Stall counter saturation
        instr_ready = 1'b0; fetch(1'b1, 32'h0000_0013, 32'h510);
        repeat (70005) step();
        #1;
        chk("sat_stall", 32'(stall_fetch), 1);
        chk("sat_count", 32'(stall_count), 32'hFFFF);

        // Asynchronous reset mid-operation
        #2 reset_n = 1'b0; #1;
        chk("arst_valid", 32'(instr_valid), 0);
        chk("arst_ready", 32'(fetch_ready), 1);
        chk("arst_stall_count", 32'(stall_count), 0);
        step(); reset_n = 1'b1; fetch(1'b1, 32'h0000_0013, 32'h0);
        step(); fetch(1'b0, 0, 0); #1;
        expect_instr("arst_first", 32'h0000_0013, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
